// File: rtl/multi_mod_counter_pkg.sv
// Shared types and parameter limits for the multi-channel modulo counter.
// Operation decode is shared so every channel resolves clr > load > inc/dec > hold the same way.
package multi_mod_counter_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } count_op_e;

    localparam int unsigned COUNT_MIN  = 2;
    localparam int unsigned COUNT_MAX  = 65536;
    localparam int unsigned NUM_CH_MIN = 1;
    localparam int unsigned NUM_CH_MAX = 16;

    // Opposing inc and dec cancel out to a hold.
    function automatic count_op_e decode_op(input logic clr, input logic load,
                                            input logic inc, input logic dec);
        count_op_e op;
        op = OP_HOLD;
        if (clr) begin
            op = OP_CLR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (inc && !dec) begin
            op = OP_INC;
        end else if (dec && !inc) begin
            op = OP_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/mod_counter_ch.sv
// One modulo-COUNT up/down counter channel with registered wrap and load-error pulses.
// carry_out/borrow_out flag a same-cycle up/down wrap for chaining into the next channel.
module mod_counter_ch
    import multi_mod_counter_pkg::*;
#(
    parameter  int COUNT = 6,
    localparam int W     = $clog2(COUNT)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         carry_in,
    input  logic         borrow_in,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         load_err,
    output logic         carry_out,
    output logic         borrow_out
);

    localparam logic [W-1:0] MAX_VAL   = W'(COUNT - 1);
    localparam logic [W:0]   COUNT_EXT = (W + 1)'(COUNT);

    count_op_e    op;
    logic [W-1:0] count_d, count_q;
    logic         wrap_d, wrap_q;
    logic         err_d, err_q;

    always_comb begin
        op         = decode_op(clr, load, inc | carry_in, dec | borrow_in);
        count_d    = count_q;
        wrap_d     = 1'b0;
        err_d      = 1'b0;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        case (op)
            OP_CLR: count_d = '0;
            OP_LOAD: begin
                // Widened compare so a power-of-two COUNT never flags an error.
                if ({1'b0, load_val} >= COUNT_EXT) begin
                    count_d = MAX_VAL;
                    err_d   = 1'b1;
                end else begin
                    count_d = load_val;
                end
            end
            OP_INC: begin
                if (count_q == MAX_VAL) begin
                    count_d   = '0;
                    wrap_d    = 1'b1;
                    carry_out = 1'b1;
                end else begin
                    count_d = count_q + W'(1);
                end
            end
            OP_DEC: begin
                if (count_q == '0) begin
                    count_d    = MAX_VAL;
                    wrap_d     = 1'b1;
                    borrow_out = 1'b1;
                end else begin
                    count_d = count_q - W'(1);
                end
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;

endmodule

// File: rtl/multi_mod_counter.sv
// NUM_CH independent modulo-COUNT counters; defining MULTI_MOD_COUNTER_CASCADE_EN chains
// each channel's wrap into the next, forming a NUM_CH-digit radix-COUNT counter.
module multi_mod_counter
    import multi_mod_counter_pkg::*;
#(
    parameter  int COUNT  = 6,
    parameter  int NUM_CH = 4,
    localparam int W      = $clog2(COUNT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        inc,
    input  logic [NUM_CH-1:0]        dec,
    input  logic [NUM_CH-1:0]        clr,
    input  logic [NUM_CH-1:0]        load,
    input  logic [NUM_CH-1:0][W-1:0] load_val,
    output logic [NUM_CH-1:0][W-1:0] out,
    output logic [NUM_CH-1:0]        wrap,
    output logic [NUM_CH-1:0]        load_err
);

    if ((COUNT < COUNT_MIN) || (COUNT > COUNT_MAX) ||
        (NUM_CH < NUM_CH_MIN) || (NUM_CH > NUM_CH_MAX)) begin : g_param_err
        $error("multi_mod_counter: COUNT or NUM_CH outside legal range");
    end

    logic [NUM_CH-1:0] carry;
    logic [NUM_CH-1:0] borrow;
    logic [NUM_CH-1:0] carry_in;
    logic [NUM_CH-1:0] borrow_in;
    logic              unused_chain;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
`ifdef MULTI_MOD_COUNTER_CASCADE_EN
        if (k == 0) begin : g_head
            assign carry_in[k]  = 1'b0;
            assign borrow_in[k] = 1'b0;
        end else begin : g_link
            assign carry_in[k]  = carry[k-1];
            assign borrow_in[k] = borrow[k-1];
        end
`else
        assign carry_in[k]  = 1'b0;
        assign borrow_in[k] = 1'b0;
`endif

        mod_counter_ch #(
            .COUNT(COUNT)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc[k]),
            .dec       (dec[k]),
            .clr       (clr[k]),
            .load      (load[k]),
            .load_val  (load_val[k]),
            .carry_in  (carry_in[k]),
            .borrow_in (borrow_in[k]),
            .count     (out[k]),
            .wrap      (wrap[k]),
            .load_err  (load_err[k]),
            .carry_out (carry[k]),
            .borrow_out(borrow[k])
        );
    end

`ifdef MULTI_MOD_COUNTER_CASCADE_EN
    assign unused_chain = carry[NUM_CH-1] ^ borrow[NUM_CH-1];
`else
    assign unused_chain = ^{carry, borrow};
`endif

endmodule

// File: tb/tb_multi_mod_counter.sv
// Scoreboard bench for multi_mod_counter (COUNT=6, 4 channels); cascade scenarios
// run only when MULTI_MOD_COUNTER_CASCADE_EN is defined.
module tb_multi_mod_counter;

    localparam int COUNT = 6;
    localparam int NCH   = 4;
    localparam int W     = $clog2(COUNT);

    typedef struct packed {
        logic [NCH-1:0][W-1:0] out;
        logic [NCH-1:0]        wrap;
        logic [NCH-1:0]        err;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NCH-1:0]        inc = '0;
    logic [NCH-1:0]        dec = '0;
    logic [NCH-1:0]        clr = '0;
    logic [NCH-1:0]        load = '0;
    logic [NCH-1:0][W-1:0] load_val = '0;
    logic [NCH-1:0][W-1:0] out;
    logic [NCH-1:0]        wrap;
    logic [NCH-1:0]        load_err;

    exp_t sb[$];
    int   mcnt[NCH];
    int   errors = 0;
    int   checks = 0;

    multi_mod_counter #(
        .COUNT (COUNT),
        .NUM_CH(NCH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (inc),
        .dec     (dec),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .out     (out),
        .wrap    (wrap),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of requests, push the model's expected post-edge outputs, step the clock.
    task automatic drive(input logic [NCH-1:0] i_inc, input logic [NCH-1:0] i_dec,
                         input logic [NCH-1:0] i_clr, input logic [NCH-1:0] i_load,
                         input logic [NCH-1:0][W-1:0] i_lv);
        exp_t e;
        logic up_c;
        logic dn_c;
        logic up;
        logic dn;
        inc = i_inc; dec = i_dec; clr = i_clr; load = i_load; load_val = i_lv;
        e = '0;
        up_c = 1'b0;
        dn_c = 1'b0;
        for (int k = 0; k < NCH; k++) begin
`ifdef MULTI_MOD_COUNTER_CASCADE_EN
            up = i_inc[k] | up_c;
            dn = i_dec[k] | dn_c;
`else
            up = i_inc[k];
            dn = i_dec[k];
`endif
            up_c = 1'b0;
            dn_c = 1'b0;
            if (i_clr[k]) begin
                mcnt[k] = 0;
            end else if (i_load[k]) begin
                if (int'(i_lv[k]) >= COUNT) begin
                    mcnt[k] = COUNT - 1;
                    e.err[k] = 1'b1;
                end else begin
                    mcnt[k] = int'(i_lv[k]);
                end
            end else if (up && !dn) begin
                mcnt[k] = (mcnt[k] + 1) % COUNT;
                e.wrap[k] = (mcnt[k] == 0);
                up_c = e.wrap[k];
            end else if (dn && !up) begin
                e.wrap[k] = (mcnt[k] == 0);
                dn_c = e.wrap[k];
                mcnt[k] = (mcnt[k] + COUNT - 1) % COUNT;
            end
            e.out[k] = W'(mcnt[k]);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        inc = '1;
        #1;
        checks++;
        if ({out, wrap, load_err} !== '0) begin
            errors++;
            $display("FAIL reset_async: actual=%h required=0", {out, wrap, load_err});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out, wrap, load_err} !== '0) begin
            errors++;
            $display("FAIL reset_held: actual=%h required=0", {out, wrap, load_err});
        end
        inc = '0;
        rst_n = 1'b1;
        for (int k = 0; k < NCH; k++) mcnt[k] = 0;
        sb.delete();
    endtask

    task automatic test_inc_wrap();
        exp_t e;
        int   seq[7] = '{1, 2, 3, 4, 5, 0, 1};
        for (int i = 0; i < 7; i++) begin
            drive(4'b0001, '0, '0, '0, '0);
            e = sb.pop_front();
            checks++;
            if ({out, wrap, load_err} !== e) begin
                errors++;
                $display("FAIL inc_wrap[%0d]: actual=%h required=%h", i, {out, wrap, load_err}, e);
            end
            checks++;
            if (out[0] !== W'(seq[i]) || wrap[0] !== (i == 5)) begin
                errors++;
                $display("FAIL inc_seq[%0d]: actual out=%0d wrap=%b required out=%0d wrap=%b",
                         i, out[0], wrap[0], seq[i], (i == 5));
            end
        end
    endtask

    task automatic test_dec_and_hold();
        exp_t e;
        logic [NCH-1:0] ops_inc[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        logic [NCH-1:0] ops_dec[5] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        logic [NCH-1:0] ops_clr[5] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [NCH-1:0] ops_ld[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            drive(ops_inc[i], ops_dec[i], ops_clr[i], ops_ld[i], {3'd0, 3'd0, 3'd0, 3'd3});
            e = sb.pop_front();
            checks++;
            if ({out, wrap, load_err} !== e) begin
                errors++;
                $display("FAIL dec_hold[%0d]: actual=%h required=%h", i, {out, wrap, load_err}, e);
            end
        end
        checks++;
        if (out[0] !== 3'd3 || wrap[0] !== 1'b0) begin
            errors++;
            $display("FAIL inc_dec_hold: actual out=%0d wrap=%b required out=3 wrap=0", out[0], wrap[0]);
        end
    endtask

    task automatic test_dec_wrap_const();
        exp_t e;
        drive('0, '0, 4'b0001, '0, '0);
        e = sb.pop_front();
        drive('0, 4'b0001, '0, '0, '0);
        e = sb.pop_front();
        checks++;
        if ({out, wrap, load_err} !== e || out[0] !== 3'd5 || wrap[0] !== 1'b1) begin
            errors++;
            $display("FAIL dec_wrap: actual=%h required=%h (out[0]=5 wrap[0]=1)", {out, wrap, load_err}, e);
        end
        drive('0, '0, '0, '0, '0);
        e = sb.pop_front();
        checks++;
        if ({out, wrap, load_err} !== e || wrap[0] !== 1'b0) begin
            errors++;
            $display("FAIL dec_wrap_pulse: actual=%h required=%h", {out, wrap, load_err}, e);
        end
    endtask

    task automatic test_load();
        exp_t e;
        drive('0, '0, '0, 4'b1111, {3'd4, 3'd6, 3'd0, 3'd7});
        e = sb.pop_front();
        checks++;
        if ({out, wrap, load_err} !== e || out[0] !== 3'd5 || load_err !== 4'b0101) begin
            errors++;
            $display("FAIL load_range: actual=%h required=%h", {out, wrap, load_err}, e);
        end
        drive('0, '0, '0, '0, '0);
        e = sb.pop_front();
        checks++;
        if ({out, wrap, load_err} !== e || load_err !== 4'b0000) begin
            errors++;
            $display("FAIL load_err_pulse: actual=%h required=%h", {out, wrap, load_err}, e);
        end
        drive(4'b0011, '0, 4'b0001, 4'b0011, {3'd0, 3'd0, 3'd2, 3'd4});
        e = sb.pop_front();
        checks++;
        if ({out, wrap, load_err} !== e || out[0] !== 3'd0 || out[1] !== 3'd2) begin
            errors++;
            $display("FAIL clr_load_inc: actual=%h required=%h", {out, wrap, load_err}, e);
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [NCH-1:0]        r_inc, r_dec, r_clr, r_ld;
        logic [NCH-1:0][W-1:0] r_lv;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < NCH; k++) begin
                r_inc[k] = ($urandom_range(0, 2) != 0);
                r_dec[k] = ($urandom_range(0, 2) == 0);
                r_clr[k] = ($urandom_range(0, 15) == 0);
                r_ld[k]  = ($urandom_range(0, 7) == 0);
                r_lv[k]  = W'($urandom_range(0, 7));
            end
            drive(r_inc, r_dec, r_clr, r_ld, r_lv);
            e = sb.pop_front();
            checks++;
            if ({out, wrap, load_err} !== e) begin
                errors++;
                $display("FAIL random[%0d]: actual=%h required=%h", i, {out, wrap, load_err}, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive('0, '0, '1, '0, '0);
        e = sb.pop_front();
        repeat (4) begin
            drive(4'b0001, '0, '0, '0, '0);
            e = sb.pop_front();
        end
        checks++;
        if ({out, wrap, load_err} !== e || out[0] !== 3'd4) begin
            errors++;
            $display("FAIL pre_reset_count: actual=%h required=%h", {out, wrap, load_err}, e);
        end
        inc = 4'b0001;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out, wrap, load_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: actual=%h required=0", {out, wrap, load_err});
        end
        @(posedge clk);
        #1;
        inc = '0;
        rst_n = 1'b1;
        for (int k = 0; k < NCH; k++) mcnt[k] = 0;
        sb.delete();
        repeat (2) begin
            drive('0, '0, '0, '0, '0);
            e = sb.pop_front();
            checks++;
            if ({out, wrap, load_err} !== e || wrap !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_after: actual=%h required=%h", {out, wrap, load_err}, e);
            end
        end
        drive(4'b0001, '0, '0, '0, '0);
        e = sb.pop_front();
        checks++;
        if ({out, wrap, load_err} !== e || out[0] !== 3'd1) begin
            errors++;
            $display("FAIL first_edge: actual=%h required=%h", {out, wrap, load_err}, e);
        end
    endtask

`ifdef MULTI_MOD_COUNTER_CASCADE_EN
    task automatic test_cascade_up();
        exp_t e;
        drive('0, '0, '1, '0, '0);
        e = sb.pop_front();
        for (int i = 1; i <= 36; i++) begin
            drive(4'b0001, '0, '0, '0, '0);
            e = sb.pop_front();
            checks++;
            if ({out, wrap, load_err} !== e || (int'(out[1]) * COUNT + int'(out[0])) != (i % 36) ||
                wrap[1] !== (i == 36)) begin
                errors++;
                $display("FAIL cascade_up[%0d]: actual=%h required=%h", i, {out, wrap, load_err}, e);
            end
        end
    endtask

    task automatic test_cascade_down();
        exp_t e;
        drive('0, '0, '1, '0, '0);
        e = sb.pop_front();
        drive('0, 4'b0001, '0, '0, '0);
        e = sb.pop_front();
        checks++;
        if ({out, wrap, load_err} !== e || out[1] !== 3'd5 || out[0] !== 3'd5 || wrap[1:0] !== 2'b11) begin
            errors++;
            $display("FAIL cascade_down: actual=%h required=%h", {out, wrap, load_err}, e);
        end
        drive('0, '0, '0, 4'b0011, {3'd0, 3'd0, 3'd2, 3'd5});
        e = sb.pop_front();
        drive(4'b0001, 4'b0010, '0, '0, '0);
        e = sb.pop_front();
        checks++;
        if ({out, wrap, load_err} !== e || out[1] !== 3'd2) begin
            errors++;
            $display("FAIL cascade_cancel: actual=%h required=%h", {out, wrap, load_err}, e);
        end
        drive('0, '0, '0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd5});
        e = sb.pop_front();
        drive(4'b0001, '0, '0, 4'b0010, {3'd0, 3'd0, 3'd4, 3'd0});
        e = sb.pop_front();
        checks++;
        if ({out, wrap, load_err} !== e || out[1] !== 3'd4) begin
            errors++;
            $display("FAIL cascade_block: actual=%h required=%h", {out, wrap, load_err}, e);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_inc_wrap();
        test_dec_and_hold();
        test_dec_wrap_const();
        test_load();
        test_random();
        test_reset_mid();
`ifdef MULTI_MOD_COUNTER_CASCADE_EN
        test_cascade_up();
        test_cascade_down();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
